mem_bus_arbiter: RTL

- Shares one external memory bus between the instruction-fetch port (PC/IF side) and the data port (MEM stage).
- Sequences each access with a registered grant FSM and supports variable-latency slaves through a req/ready handshake.
- Raises per-port stall requests consumed by the pipeline controller; holds and returns read data to each requester.

---
 rtl/mem_bus_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one external memory bus between the instruction-fetch
// port and the data port. Data wins when both ports request from IDLE. A grant
// lasts until the slave answers with bus_ready. Each port sees a combinational
// stall and a held copy of the last word returned to it.
// Optional watchdog: define MEM_ARB_TIMEOUT_EN to force-complete accesses that
// wait TIMEOUT grant cycles without bus_ready, and to raise a sticky bus_err.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SEL_W   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_en,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic [DATA_W-1:0] inst_rdata,
  output logic              inst_stall,
  input  logic              data_en,
  input  logic [SEL_W-1:0]  data_we,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic [DATA_W-1:0] data_rdata,
  output logic              data_stall,
  output logic              bus_req,
  output logic [SEL_W-1:0]  bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_ready,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              bus_err
);

  // Catch inconsistent parameter sets at elaboration time.
  if (SEL_W * 8 != DATA_W) begin : g_sel_w_check
    $error("SEL_W must equal DATA_W/8");
  end
  if (TIMEOUT < 1) begin : g_timeout_check
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_INST = 2'd1,
    GRANT_DATA = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic              granted;
  logic              force_done;
  logic              access_done;
  logic              inst_done;
  logic              data_done;
  logic [DATA_W-1:0] ret_data;
  logic [DATA_W-1:0] inst_rdata_reg;
  logic [DATA_W-1:0] data_rdata_reg;

  assign granted     = (state_reg != IDLE);
  assign access_done = granted && (bus_ready || force_done);
  assign inst_done   = (state_reg == GRANT_INST) && access_done;
  assign data_done   = (state_reg == GRANT_DATA) && access_done;
  // A watchdog completion returns zero instead of whatever is on the bus.
  assign ret_data    = force_done ? '0 : bus_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th waiting cycle is
  // the one that force-completes.
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0] wait_cnt_reg;
  logic             bus_err_reg;

  assign force_done = granted && !bus_ready && (wait_cnt_reg == CNT_W'(TIMEOUT - 1));
  assign bus_err    = bus_err_reg;

  // Count waiting grant cycles; zero in IDLE and on completion so every new
  // grant starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else if (!granted || access_done) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_reg + 1'b1;
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_err_reg <= 1'b0;
    end else if (force_done) begin
      bus_err_reg <= 1'b1;
    end
  end
`else
  assign force_done = 1'b0;
  assign bus_err    = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: data priority from IDLE, hand over to the other port on
  // completion so a pending fetch follows a data access with no idle bubble.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (data_en) begin
          state_next = GRANT_DATA;
        end else if (inst_en) begin
          state_next = GRANT_INST;
        end
      end
      GRANT_INST: begin
        if (access_done) begin
          state_next = data_en ? GRANT_DATA : IDLE;
        end
      end
      GRANT_DATA: begin
        if (access_done) begin
          state_next = inst_en ? GRANT_INST : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Hold the last word returned to each port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_rdata_reg <= '0;
      data_rdata_reg <= '0;
    end else begin
      if (inst_done) begin
        inst_rdata_reg <= ret_data;
      end
      if (data_done) begin
        data_rdata_reg <= ret_data;
      end
    end
  end

  // Outputs: bus driven from the granted port, stalls and read data bypass
  // the holding registers during the completing cycle.
  always_comb begin
    bus_req    = 1'b0;
    bus_we     = '0;
    bus_addr   = '0;
    bus_wdata  = '0;
    case (state_reg)
      GRANT_INST: begin
        bus_req  = 1'b1;
        bus_addr = inst_addr;
      end
      GRANT_DATA: begin
        bus_req   = 1'b1;
        bus_we    = data_we;
        bus_addr  = data_addr;
        bus_wdata = data_wdata;
      end
      default: ;
    endcase
    inst_stall = inst_en && !inst_done;
    data_stall = data_en && !data_done;
    inst_rdata = inst_done ? ret_data : inst_rdata_reg;
    data_rdata = data_done ? ret_data : data_rdata_reg;
  end

endmodule
